// File: rtl/uart_pkg.sv
// ============================================================================
// Module  : uart_pkg
// Brief   : Shared constants, receive FSM encoding and majority helper for
//           the Amber UART receive path.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam int UART_OVS       = 16;
    localparam int UART_SAMPLE_LO = 7;
    localparam int UART_SAMPLE_HI = 9;
    localparam int UART_DATA_BITS = 8;

    typedef enum logic [3:0] {
        RXD_IDLE      = 4'd0,
        RXD_START     = 4'd1,
        RXD_DATA      = 4'd2,
`ifdef AMBER_UART_RX_PARITY_EN
        RXD_PARITY    = 4'd3,
`endif
        RXD_STOP      = 4'd4,
        RXD_WAIT_HIGH = 4'd5
    } rxd_state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_deframer_if.sv
// ============================================================================
// Module  : uart_rx_deframer_if
// Brief   : Byte delivery handshake and error pulses between the UART receive
//           deframer (master) and the RX FIFO push port (slave).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface uart_rx_deframer_if;
    import uart_pkg::*;

    logic [UART_DATA_BITS-1:0] o_rx_data;
    logic                      o_rx_valid;
    logic                      i_rx_ready;
    logic                      o_frame_err;
    logic                      o_overrun;
    logic                      o_parity_err;

    modport master (
        output o_rx_data, o_rx_valid, o_frame_err, o_overrun, o_parity_err,
        input  i_rx_ready
    );

    modport slave (
        input  o_rx_data, o_rx_valid, o_frame_err, o_overrun, o_parity_err,
        output i_rx_ready
    );
endinterface

`default_nettype wire

// File: rtl/uart_baud_tick.sv
// ============================================================================
// Module  : uart_baud_tick
// Brief   : Free-running oversample tick divider with synchronous re-phase
//           clear; shared by the UART receive and transmit paths.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_baud_tick #(
    parameter int TICK_DIV = 11
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    output logic o_tick
);

    localparam int                c_cnt_w = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(TICK_DIV - 1);

    logic [c_cnt_w-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr || (r_cnt == c_last)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // A clear in the same cycle suppresses the tick so the new phase starts clean.
    assign o_tick = (r_cnt == c_last) && !i_clr;

endmodule

`default_nettype wire

// File: rtl/uart_rx_deframer.sv
// ============================================================================
// Module  : uart_rx_deframer
// Brief   : UART receive front end: pin synchroniser, 16x oversampling with
//           3-sample majority vote, 8N1 deframing (8E1 when the macro
//           AMBER_UART_RX_PARITY_EN is defined), single holding register.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_rx_deframer
    import uart_pkg::*;
#(
    parameter int TICK_DIV = 11,
    parameter int OVS      = 16
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_uart_rxd,
    uart_rx_deframer_if.master  rx
);

    generate
        if (OVS != UART_OVS) begin : g_ovs_check
            $error("uart_rx_deframer: OVS must be 16");
        end
    endgenerate

    localparam logic [2:0] c_last_bit = 3'(UART_DATA_BITS - 1);

    logic       r_rxd_meta, r_rxd_s, r_rxd_prev;
    logic [1:0] r_sync_vld;
    logic       w_fall, w_start, w_tick, w_maj, w_mid, w_end;

    rxd_state_t r_state, w_state_nxt;
    logic [3:0] r_ovs_cnt;
    logic [2:0] r_bit_cnt;
    logic [1:0] r_smp;
    logic [7:0] r_shreg;
    logic       w_shift, w_good_stop, w_bad_stop, w_bit_clr, w_bit_inc;

    logic [7:0] r_rx_data;
    logic       r_rx_valid, r_frame_err, r_overrun;

    // r_rxd_prev only follows the pin once real samples have flushed through,
    // so a line that is low at reset release never looks like a start edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rxd_meta <= 1'b1;
            r_rxd_s    <= 1'b1;
            r_rxd_prev <= 1'b0;
            r_sync_vld <= 2'b00;
        end else begin
            r_rxd_meta <= i_uart_rxd;
            r_rxd_s    <= r_rxd_meta;
            r_sync_vld <= {r_sync_vld[0], 1'b1};
            r_rxd_prev <= r_sync_vld[1] & r_rxd_s;
        end
    end

    assign w_fall  = r_rxd_prev & ~r_rxd_s;
    assign w_start = (r_state == RXD_IDLE) && w_fall;

    uart_baud_tick #(.TICK_DIV(TICK_DIV)) u_tick (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (w_start),
        .o_tick  (w_tick)
    );

    assign w_maj = maj3(r_smp[0], r_smp[1], r_rxd_s);
    assign w_mid = w_tick && (r_ovs_cnt == 4'(UART_SAMPLE_HI));
    assign w_end = w_tick && (r_ovs_cnt == 4'(UART_OVS - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= RXD_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_shift     = 1'b0;
        w_good_stop = 1'b0;
        w_bad_stop  = 1'b0;
        w_bit_clr   = 1'b0;
        w_bit_inc   = 1'b0;
        case (r_state)
            RXD_IDLE: if (w_fall) w_state_nxt = RXD_START;
            RXD_START: begin
                if (w_mid && w_maj) begin
                    w_state_nxt = RXD_IDLE;
                end else if (w_end) begin
                    w_state_nxt = RXD_DATA;
                    w_bit_clr   = 1'b1;
                end
            end
            RXD_DATA: begin
                w_shift = w_mid;
                if (w_end) begin
                    w_bit_inc = 1'b1;
                    if (r_bit_cnt == c_last_bit) begin
`ifdef AMBER_UART_RX_PARITY_EN
                        w_state_nxt = RXD_PARITY;
`else
                        w_state_nxt = RXD_STOP;
`endif
                    end
                end
            end
`ifdef AMBER_UART_RX_PARITY_EN
            RXD_PARITY: if (w_end) w_state_nxt = RXD_STOP;
`endif
            // The stop decision is taken at mid-bit so a fast transmitter's
            // next start edge is not missed.
            RXD_STOP: begin
                if (w_mid) begin
                    if (w_maj) begin
                        w_good_stop = 1'b1;
                        w_state_nxt = RXD_IDLE;
                    end else begin
                        w_bad_stop  = 1'b1;
                        w_state_nxt = RXD_WAIT_HIGH;
                    end
                end
            end
            RXD_WAIT_HIGH: if (r_rxd_s) w_state_nxt = RXD_IDLE;
            default:       w_state_nxt = RXD_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ovs_cnt   <= '0;
            r_bit_cnt   <= '0;
            r_smp       <= 2'b11;
            r_shreg     <= '0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_start)     r_ovs_cnt <= '0;
            else if (w_tick) r_ovs_cnt <= r_ovs_cnt + 4'd1;

            if (w_bit_clr)      r_bit_cnt <= '0;
            else if (w_bit_inc) r_bit_cnt <= r_bit_cnt + 3'd1;

            if (w_tick && (r_ovs_cnt == 4'(UART_SAMPLE_LO)))     r_smp[0] <= r_rxd_s;
            if (w_tick && (r_ovs_cnt == 4'(UART_SAMPLE_LO + 1))) r_smp[1] <= r_rxd_s;

            if (w_shift) r_shreg <= {w_maj, r_shreg[7:1]};

            r_frame_err <= w_bad_stop;
            r_overrun   <= w_good_stop && r_rx_valid && !rx.i_rx_ready;

            if (w_good_stop && (!r_rx_valid || rx.i_rx_ready)) begin
                r_rx_data  <= r_shreg;
                r_rx_valid <= 1'b1;
            end else if (r_rx_valid && rx.i_rx_ready) begin
                r_rx_valid <= 1'b0;
            end
        end
    end

`ifdef AMBER_UART_RX_PARITY_EN
    logic r_par_bad, r_parity_err;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_par_bad    <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            if ((r_state == RXD_PARITY) && w_mid) r_par_bad <= w_maj ^ (^r_shreg);
            r_parity_err <= w_good_stop && r_par_bad;
        end
    end

    assign rx.o_parity_err = r_parity_err;
`else
    assign rx.o_parity_err = 1'b0;
`endif

    assign rx.o_rx_data   = r_rx_data;
    assign rx.o_rx_valid  = r_rx_valid;
    assign rx.o_frame_err = r_frame_err;
    assign rx.o_overrun   = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_deframer.sv
// ============================================================================
// Module  : tb_uart_rx_deframer
// Brief   : Self-checking bench: serial frame driver, byte scoreboard and
//           error-pulse counters; table of frames plus corner sequences.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_deframer;
    import uart_pkg::*;

    localparam int TD       = 4;
    localparam int BIT_CLKS = 16 * TD;
`ifdef AMBER_UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    localparam int LAT_NOM = 2 + (9 * 16 + 10) * TD + (PAR_EN ? 16 * TD : 0);

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       flip;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    logic rxd;
    int   total = 0, bad = 0;
    int   cyc = 0, fall_cyc = 0, rise_cyc = 0;
    int   n_ferr = 0, n_ovr = 0, n_perr = 0, n_xfer = 0;
    logic valid_d = 1'b0;
    logic [7:0] exp_q[$];

    uart_rx_deframer_if rx_if();

    uart_rx_deframer #(.TICK_DIV(TD), .OVS(16)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_uart_rxd (rxd),
        .rx         (rx_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard and pulse counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (rx_if.o_frame_err)  n_ferr++;
        if (rx_if.o_overrun)    n_ovr++;
        if (rx_if.o_parity_err) n_perr++;
        if (rx_if.o_rx_valid && !valid_d) rise_cyc = cyc;
        valid_d = rx_if.o_rx_valid;
        if (rx_if.o_rx_valid && rx_if.i_rx_ready) begin
            n_xfer++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_byte: got 0x%0h, want none", rx_if.o_rx_data);
            end else begin
                check("rx_data", int'(rx_if.o_rx_data), int'(exp_q.pop_front()));
            end
        end
    end

    task automatic drive_bit(input logic b);
        rxd = b;
        repeat (BIT_CLKS) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic flip, input logic stop);
        fall_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (PAR_EN) drive_bit((^d) ^ flip);
        drive_bit(stop);
    endtask

    task automatic idle_bits(input int n);
        rxd = 1'b1;
        repeat (n * BIT_CLKS) @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1);
    end

    initial begin
        vec_t vecs[6];
        int   f0, o0, p0, x0, lat, lat_use;

        vecs[0] = '{8'h00, 1'b1, 1'b0};
        vecs[1] = '{8'hFF, 1'b1, 1'b0};
        vecs[2] = '{8'h81, 1'b1, 1'b0};
        vecs[3] = '{8'h6E, 1'b0, 1'b0};
        vecs[4] = '{8'hC3, 1'b1, 1'b1};
        vecs[5] = '{8'h5A, 1'b1, 1'b0};

        rst_n = 1'b0;
        rxd   = 1'b1;
        rx_if.i_rx_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b1;
        check("reset_valid", int'(rx_if.o_rx_valid), 0);
        check("reset_data", int'(rx_if.o_rx_data), 0);
        check("reset_errs", int'({rx_if.o_frame_err, rx_if.o_overrun, rx_if.o_parity_err}), 0);
        idle_bits(1);

        // Byte A5 with latency measurement.
        f0 = n_ferr; o0 = n_ovr; p0 = n_perr;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b0, 1'b1);
        idle_bits(1);
        lat = rise_cyc - fall_cyc;
        check("a5_delivered", exp_q.size(), 0);
        check("a5_latency_ok", int'((lat >= LAT_NOM - TD - 1) && (lat <= LAT_NOM + TD + 1)), 1);
        check("a5_no_errs", (n_ferr - f0) + (n_ovr - o0) + (n_perr - p0), 0);
        lat_use = ((lat >= LAT_NOM - TD - 1) && (lat <= LAT_NOM + TD + 1)) ? lat : LAT_NOM;

        for (int i = 0; i < 6; i++) begin
            f0 = n_ferr; o0 = n_ovr; p0 = n_perr;
            if (vecs[i].stop) exp_q.push_back(vecs[i].data);
            send_frame(vecs[i].data, vecs[i].flip, vecs[i].stop);
            idle_bits(2);
            check($sformatf("vec%0d_queue", i), exp_q.size(), 0);
            check($sformatf("vec%0d_ferr", i), n_ferr - f0, vecs[i].stop ? 0 : 1);
            check($sformatf("vec%0d_perr", i), n_perr - p0, (PAR_EN && vecs[i].stop) ? int'(vecs[i].flip) : 0);
            check($sformatf("vec%0d_ovr", i), n_ovr - o0, 0);
        end

        // Glitch shorter than half a bit.
        f0 = n_ferr; x0 = n_xfer;
        rxd = 1'b0;
        repeat (4 * TD) @(posedge clk);
        #1 idle_bits(12);
        check("glitch_no_xfer", n_xfer - x0, 0);
        check("glitch_no_ferr", n_ferr - f0, 0);

        // Stop bit low, line stuck low, then recovery.
        f0 = n_ferr; x0 = n_xfer;
        send_frame(8'h55, 1'b0, 1'b0);
        rxd = 1'b0;
        repeat (40 * BIT_CLKS) @(posedge clk);
        #1 idle_bits(2);
        check("brk_ferr_once", n_ferr - f0, 1);
        check("brk_no_xfer", n_xfer - x0, 0);
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b0, 1'b1);
        idle_bits(2);
        check("brk_recover", exp_q.size(), 0);
        check("brk_no_more_ferr", n_ferr - f0, 1);

        // Overrun: second byte dropped while the first is held.
        o0 = n_ovr; x0 = n_xfer;
        rx_if.i_rx_ready = 1'b0;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b0, 1'b1);
        idle_bits(1);
        send_frame(8'h22, 1'b0, 1'b1);
        idle_bits(1);
        check("ovr_pulse", n_ovr - o0, 1);
        check("ovr_valid_held", int'(rx_if.o_rx_valid), 1);
        check("ovr_data_held", int'(rx_if.o_rx_data), 'h11);
        check("ovr_no_xfer", n_xfer - x0, 0);
        rx_if.i_rx_ready = 1'b1;
        idle_bits(2);
        check("ovr_one_xfer", n_xfer - x0, 1);
        check("ovr_queue", exp_q.size(), 0);

        // Ready asserted exactly on the completion cycle of the second byte.
        o0 = n_ovr;
        rx_if.i_rx_ready = 1'b0;
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        send_frame(8'h11, 1'b0, 1'b1);
        idle_bits(1);
        fork
            send_frame(8'h22, 1'b0, 1'b1);
            begin
                repeat (lat_use - 1) @(posedge clk);
                #1 rx_if.i_rx_ready = 1'b1;
                @(posedge clk);
                #1 rx_if.i_rx_ready = 1'b0;
            end
        join
        idle_bits(1);
        check("sim_no_ovr", n_ovr - o0, 0);
        check("sim_data", int'(rx_if.o_rx_data), 'h22);
        check("sim_valid", int'(rx_if.o_rx_valid), 1);
        rx_if.i_rx_ready = 1'b1;
        idle_bits(1);
        check("sim_queue", exp_q.size(), 0);

        // Reset in the middle of the data bits.
        f0 = n_ferr; x0 = n_xfer;
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        rst_n = 1'b0;
        rxd   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mid_valid", int'(rx_if.o_rx_valid), 0);
        check("rst_mid_data", int'(rx_if.o_rx_data), 0);
        rst_n = 1'b1;
        idle_bits(3);
        check("rst_mid_no_xfer", n_xfer - x0, 0);
        check("rst_mid_no_ferr", n_ferr - f0, 0);
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b0, 1'b1);
        idle_bits(2);
        check("rst_mid_next", exp_q.size(), 0);

`ifdef AMBER_UART_RX_PARITY_EN
        // 07 has odd weight, so a parity bit of 0 is wrong for even parity.
        p0 = n_perr;
        exp_q.push_back(8'h07);
        send_frame(8'h07, 1'b1, 1'b1);
        idle_bits(2);
        check("par_err_pulse", n_perr - p0, 1);
        check("par_delivered", exp_q.size(), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
